// File: rtl/step_pkg.sv
// Shared types and defaults for the push-button step pulse generator.
package step_pkg;

  // Debounce FSM state encoding.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DB_PRESS   = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_DB_RELEASE = 2'd3
  } step_state_e;

  localparam int unsigned DB_CYCLES_DEF     = 16;
  localparam int unsigned PULSE_LEN_DEF     = 2;
  localparam int unsigned CNT_W_DEF         = 8;
  localparam int unsigned REPEAT_DELAY_DEF  = 64;
  localparam int unsigned REPEAT_PERIOD_DEF = 16;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val <= 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/step_pulse_stretch.sv
// Turns a one-cycle fire strobe into a registered pulse exactly PULSE_LEN
// cycles wide. Fires arriving while the pulse is high are dropped.
module step_pulse_stretch
  import step_pkg::*;
#(
  parameter int unsigned PULSE_LEN = PULSE_LEN_DEF
) (
  input  logic c,
  input  logic r,
  input  logic fire,
  output logic p
);

  localparam int unsigned LW = cnt_width(PULSE_LEN - 1);

  logic          p_q, p_d;
  logic [LW-1:0] len_q, len_d;

  // Next pulse state: load on fire when idle, count down while high.
  always_comb begin
    p_d   = p_q;
    len_d = len_q;
    if (p_q) begin
      if (len_q == '0) begin
        p_d = 1'b0;
      end else begin
        len_d = len_q - LW'(1);
      end
    end else if (fire) begin
      p_d   = 1'b1;
      len_d = LW'(PULSE_LEN - 1);
    end
  end

  // Pulse registers; reset truncates a pulse in flight immediately.
  always_ff @(posedge c or posedge r) begin
    if (r) begin
      p_q   <= 1'b0;
      len_q <= '0;
    end else begin
      p_q   <= p_d;
      len_q <= len_d;
    end
  end

  assign p = p_q;

endmodule

// File: rtl/step_pulse_gen.sv
// Push-button to step-pulse front end: 2-flop synchronizer, debounce FSM and
// pulse stretcher. One accepted press yields one PULSE_LEN-wide pulse on p.
// Optional auto-repeat while held is enabled by defining STEP_AUTOREPEAT_EN.
module step_pulse_gen
  import step_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = DB_CYCLES_DEF,
  parameter int unsigned PULSE_LEN     = PULSE_LEN_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF,
  parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic c,
  input  logic r,
  input  logic btn,
  output logic p,
  output logic held,
  output logic busy
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  // Elaboration-time parameter sanity checks.
  if (DB_CYCLES < 2) begin : g_chk_db
    $error("step_pulse_gen: DB_CYCLES must be >= 2");
  end
  if (PULSE_LEN < 1) begin : g_chk_pl
    $error("step_pulse_gen: PULSE_LEN must be >= 1");
  end
  if ($clog2(DB_CYCLES) > CNT_W) begin : g_chk_cw_db
    $error("step_pulse_gen: CNT_W too narrow for DB_CYCLES");
  end
  if (REPEAT_PERIOD <= PULSE_LEN) begin : g_chk_rp
    $error("step_pulse_gen: REPEAT_PERIOD must exceed PULSE_LEN");
  end
  if ($clog2(REPEAT_DELAY) > CNT_W) begin : g_chk_cw_rd
    $error("step_pulse_gen: CNT_W too narrow for REPEAT_DELAY");
  end

  logic             s1_q, s2_q;
  step_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             held_q, busy_q;
  logic             fire_press_c;
  logic             fire_c;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge c or posedge r) begin
    if (r) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn;
      s2_q <= s1_q;
    end
  end

  // Press accepted: last stable debounce cycle with the button still high.
  always_comb begin
    fire_press_c = (state_q == ST_DB_PRESS) && s2_q && (cnt_q == DB_LAST);
  end

  // Debounce FSM with registered held/busy flags.
  always_ff @(posedge c or posedge r) begin
    if (r) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      held_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (s2_q) begin
            state_q <= ST_DB_PRESS;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_DB_PRESS: begin
          if (!s2_q) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == DB_LAST) begin
            state_q <= ST_PRESSED;
            held_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_PRESSED: begin
          if (!s2_q) begin
            state_q <= ST_DB_RELEASE;
            cnt_q   <= '0;
          end
        end
        ST_DB_RELEASE: begin
          if (s2_q) begin
            state_q <= ST_PRESSED;
          end else if (cnt_q == DB_LAST) begin
            state_q <= ST_IDLE;
            held_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          held_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef STEP_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rep_q, rep_d;
  logic             first_q, first_d;
  logic             fire_rep_c;

  // Repeat timer: initial delay, then fixed period, only while staying PRESSED.
  always_comb begin
    rep_d      = rep_q;
    first_d    = first_q;
    fire_rep_c = 1'b0;
    if ((state_q == ST_PRESSED) && s2_q) begin
      if (rep_q == (first_q ? RD_LAST : RP_LAST)) begin
        fire_rep_c = 1'b1;
        rep_d      = '0;
        first_d    = 1'b0;
      end else begin
        rep_d = rep_q + CNT_W'(1);
      end
    end else begin
      rep_d   = '0;
      first_d = 1'b1;
    end
  end

  // Repeat timer registers.
  always_ff @(posedge c or posedge r) begin
    if (r) begin
      rep_q   <= '0;
      first_q <= 1'b1;
    end else begin
      rep_q   <= rep_d;
      first_q <= first_d;
    end
  end

  assign fire_c = fire_press_c | fire_rep_c;
`else
  assign fire_c = fire_press_c;
`endif

  step_pulse_stretch #(
    .PULSE_LEN(PULSE_LEN)
  ) u_stretch (
    .c   (c),
    .r   (r),
    .fire(fire_c),
    .p   (p)
  );

  assign held = held_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Scoreboard bench for step_pulse_gen: expected pulse edges are queued as the
// button is driven and popped when p rises; a 3-bit step counter on p models
// the downstream ripple counter.
module tb_step_pulse_gen;

  localparam int DB = 4;
  localparam int PL = 2;
  localparam int RD = 8;
  localparam int RP = 4;

  logic c   = 1'b0;
  logic r   = 1'b1;
  logic btn = 1'b0;
  logic p, held, busy;

  step_pulse_gen #(
    .DB_CYCLES    (DB),
    .PULSE_LEN    (PL),
    .CNT_W        (8),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .c   (c),
    .r   (r),
    .btn (btn),
    .p   (p),
    .held(held),
    .busy(busy)
  );

  always #5 c = ~c;

  int cyc = 0;
  always @(posedge c) cyc <= cyc + 1;

  int       n_tot = 0;
  int       n_bad = 0;
  int       exp_q[$];
  int       exp_steps = 0;
  logic [2:0] steps = 3'd0;
  bit       trunc = 1'b0;

  // Downstream 3-bit counter clocked by p.
  always @(posedge p) steps <= steps + 3'd1;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_tot++;
    if (obs != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Pulse monitor: pops expected rise edge, checks width on fall.
  logic p_prev = 1'b0;
  int   rise_e = 0;
  always @(negedge c) begin
    if (p && !p_prev) begin
      rise_e = cyc;
      if (exp_q.size() == 0) chk("pulse_unexpected", cyc, -1);
      else                   chk("pulse_edge", cyc, exp_q.pop_front());
    end
    if (!p && p_prev && !trunc) chk("pulse_width", cyc - rise_e, PL);
    p_prev = p;
  end

  task automatic wait_to(input int e);
    while (cyc < e) @(negedge c);
  endtask

  // Queue the pulses a clean hold from sample edge e_first to release sample e_rel yields.
  task automatic push_pulses(input int e_first, input int e_rel);
    exp_q.push_back(e_first + DB + 2);
    exp_steps++;
`ifdef STEP_AUTOREPEAT_EN
    for (int t = e_first + DB + 2 + RD; t < e_rel + 2; t += RP) begin
      exp_q.push_back(t);
      exp_steps++;
    end
`endif
  endtask

  task automatic clean_press(input int hold);
    int a;
    a = cyc + 1;
    btn = 1'b1;
    push_pulses(a, a + hold);
    wait_to(a + DB + 1);
    chk("held_early", int'(held), 0);
    chk("busy_db", int'(busy), 1);
    wait_to(a + DB + 2);
    chk("held_on", int'(held), 1);
    wait_to(a + hold - 1);
    btn = 1'b0;
    wait_to(a + hold + DB + 1);
    chk("held_rel_db", int'(held), 1);
    wait_to(a + hold + DB + 2);
    chk("held_off", int'(held), 0);
    chk("busy_off", int'(busy), 0);
    wait_to(cyc + 2);
    chk("steps", int'(steps), exp_steps % 8);
  endtask

  initial begin
    int a, k;
    // Reset for two cycles.
    @(negedge c);
    chk("rst_p", int'(p), 0);
    chk("rst_held", int'(held), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge c);
    r = 1'b0;
    wait_to(cyc + 3);
    chk("idle_busy", int'(busy), 0);

    // Clean presses: counter walks 1..7 and wraps to 0.
    for (int i = 0; i < 8; i++) clean_press(20);

    // Press bounce: 1,0,1,0,1,0 then steady 1.
    a = cyc + 1;
    push_pulses(a + 6, a + 16);
    for (int i = 0; i < 7; i++) begin
      btn = (i % 2 == 0);
      if (i < 6) @(negedge c);
    end
    wait_to(a + 11);
    chk("bounce_held_pre", int'(held), 0);
    wait_to(a + 12);
    chk("bounce_held_on", int'(held), 1);
    wait_to(a + 15);
    btn = 1'b0;
    wait_to(a + 16 + DB + 2);
    chk("bounce_held_off", int'(held), 0);
    chk("bounce_busy_off", int'(busy), 0);
    chk("bounce_steps", int'(steps), exp_steps % 8);

    // Short press: three samples high, rejected.
    a = cyc + 1;
    btn = 1'b1;
    wait_to(a + 2);
    btn = 1'b0;
    wait_to(a + 4);
    chk("short_busy_on", int'(busy), 1);
    wait_to(a + 5);
    chk("short_busy_off", int'(busy), 0);
    chk("short_held", int'(held), 0);
    wait_to(a + 10);
    chk("short_p", int'(p), 0);

    // Release bounce: 0,0,1 then steady 0; no second pulse.
    a = cyc + 1;
    btn = 1'b1;
    push_pulses(a, a + 9);
    wait_to(a + 8);
    btn = 1'b0;
    wait_to(a + 10);
    btn = 1'b1;
    wait_to(a + 11);
    btn = 1'b0;
    wait_to(a + 13);
    chk("relb_held_mid", int'(held), 1);
    wait_to(a + 12 + DB + 1);
    chk("relb_held_late", int'(held), 1);
    wait_to(a + 12 + DB + 2);
    chk("relb_held_off", int'(held), 0);
    chk("relb_busy_off", int'(busy), 0);
    wait_to(cyc + 4);
    chk("relb_steps", int'(steps), exp_steps % 8);

    // Reset mid-pulse with button held, then a fresh debounce.
    a = cyc + 1;
    btn = 1'b1;
    exp_q.push_back(a + DB + 2);
    exp_steps++;
    wait_to(a + DB + 2);
    chk("mid_p_before", int'(p), 1);
    #2;
    trunc = 1'b1;
    r = 1'b1;
    #1;
    chk("mid_rst_p", int'(p), 0);
    chk("mid_rst_held", int'(held), 0);
    chk("mid_rst_busy", int'(busy), 0);
    @(negedge c);
    @(negedge c);
    r = 1'b0;
    trunc = 1'b0;
    k = cyc;
    push_pulses(k + 1, k + 11);
    wait_to(k + DB + 2);
    chk("post_rst_held_pre", int'(held), 0);
    wait_to(k + DB + 3);
    chk("post_rst_held_on", int'(held), 1);
    wait_to(k + 10);
    btn = 1'b0;
    wait_to(k + 11 + DB + 2);
    chk("post_rst_held_off", int'(held), 0);
    chk("post_rst_busy_off", int'(busy), 0);
    wait_to(cyc + 2);
    chk("post_rst_steps", int'(steps), exp_steps % 8);

`ifdef STEP_AUTOREPEAT_EN
    // Auto-repeat: hold for 30 cycles.
    clean_press(30);
`endif

    wait_to(cyc + 10);
    chk("pending_pulses", exp_q.size(), 0);
    chk("final_p", int'(p), 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: no finish by edge %0d", cyc);
    $fatal(1);
  end

endmodule
